// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with press-step and hold-to-repeat.
// Wraps or saturates at 0 and MAX_VALUE.
module bcd_updown_counter #(
  parameter int NUM_DIGITS    = 2,
  parameter int MAX_VALUE     = 99,
  parameter bit WRAP          = 1'b1,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Up,
  input  logic                    i_Down,
  output logic [4*NUM_DIGITS-1:0] o_Digits,
  output logic                    o_Wrap,
  output logic                    o_Limit
);

  localparam int W       = 4 * NUM_DIGITS;
  localparam int CNT_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] DELAY_CNT  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_CNT = CW'(REPEAT_PERIOD);

  function automatic logic [W-1:0] to_bcd(input int value);
    int v;
    logic [W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] value);
    logic [W-1:0] r;
    logic carry;
    r     = value;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] value);
    logic [W-1:0] r;
    logic borrow;
    r      = value;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state, state_n;
  logic          dir_up, dir_up_n;
  logic [CW-1:0] count, count_n;
  logic          prev_up, prev_down;
  logic [W-1:0]  digits, digits_n;
  logic          wrap_q, wrap_n;
  logic          limit_q, limit_n;
  logic          up_edge, down_edge, held, other;
  logic          do_step, step_up;

  assign up_edge   = i_Up & ~prev_up;
  assign down_edge = i_Down & ~prev_down;
  assign held      = dir_up ? i_Up : i_Down;
  assign other     = dir_up ? i_Down : i_Up;

  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    count_n  = count;
    do_step  = 1'b0;
    step_up  = dir_up;
    case (state)
      IDLE: begin
        if (up_edge && !i_Down) begin
          do_step  = 1'b1;
          step_up  = 1'b1;
          dir_up_n = 1'b1;
          count_n  = CW'(1);
          state_n  = DELAY;
        end else if (down_edge && !i_Up) begin
          do_step  = 1'b1;
          step_up  = 1'b0;
          dir_up_n = 1'b0;
          count_n  = CW'(1);
          state_n  = DELAY;
        end
      end
      // Both hold states abort on release or on any activity of the other button.
      DELAY, REPEAT: begin
        if (!held || other) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count == ((state == DELAY) ? DELAY_CNT : PERIOD_CNT)) begin
          do_step = 1'b1;
          count_n = CW'(1);
          state_n = REPEAT;
        end else begin
          count_n = count + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  always_comb begin
    digits_n = digits;
    wrap_n   = 1'b0;
    limit_n  = 1'b0;
    if (do_step) begin
      if (step_up) begin
        if (digits == MAX_BCD) begin
          if (WRAP) begin
            digits_n = '0;
            wrap_n   = 1'b1;
          end else begin
            limit_n = 1'b1;
          end
        end else begin
          digits_n = bcd_inc(digits);
        end
      end else begin
        if (digits == '0) begin
          if (WRAP) begin
            digits_n = MAX_BCD;
            wrap_n   = 1'b1;
          end else begin
            limit_n = 1'b1;
          end
        end else begin
          digits_n = bcd_dec(digits);
        end
      end
    end
  end

  // Previous samples reset high so a button held through reset needs a fresh press.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      count     <= '0;
      digits    <= '0;
      wrap_q    <= 1'b0;
      limit_q   <= 1'b0;
      prev_up   <= 1'b1;
      prev_down <= 1'b1;
    end else begin
      state     <= state_n;
      dir_up    <= dir_up_n;
      count     <= count_n;
      digits    <= digits_n;
      wrap_q    <= wrap_n;
      limit_q   <= limit_n;
      prev_up   <= i_Up;
      prev_down <= i_Down;
    end
  end

  assign o_Digits = digits;
  assign o_Wrap   = wrap_q;
  assign o_Limit  = limit_q;

endmodule
